ceespu_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the ceespu pipeline.
- Tracks in-flight register writes in a shifting scoreboard of FWD_DEPTH post-decode stages.
- Selects the forwarded operand per source from any stage, and generates load-use stall/bubble, busy freeze and branch flush.
- Sits between decode and execute. It replaces ad-hoc fixed two-stage forwarding and supports deeper memory pipelines (LOAD_LAT > 0) with a stall-cycle counter.

---
 rtl/ceespu_hazard_unit_if.sv | 51 +++++
 rtl/ceespu_hazard_unit.sv | 114 +++++++++++
 tb/tb_ceespu_hazard_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ceespu_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ceespu_hazard_unit_if
// Description : Decode/execute hazard bus between the ceespu pipeline and
//               its hazard/forwarding controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ceespu_hazard_unit_if #(
  parameter int XLEN      = 32,
  parameter int REGW      = 5,
  parameter int FWD_DEPTH = 2
);
  logic                      I_dec_valid;
  logic [REGW-1:0]           I_dec_regA;
  logic [REGW-1:0]           I_dec_regB;
  logic                      I_dec_useA;
  logic                      I_dec_useB;
  logic                      I_dec_we;
  logic [REGW-1:0]           I_dec_regD;
  logic                      I_dec_isLoad;
  logic                      I_branch;
  logic                      I_ex_busy;
  logic                      I_dmem_busy;
  logic [FWD_DEPTH*XLEN-1:0] I_stage_data;
  logic [XLEN-1:0]           I_regA;
  logic [XLEN-1:0]           I_regB;
  logic [XLEN-1:0]           O_opA;
  logic [XLEN-1:0]           O_opB;
  logic [2:0]                O_fwdA;
  logic [2:0]                O_fwdB;
  logic                      O_stall;
  logic                      O_bubble;
  logic [31:0]               O_stall_cycles;

  // Pipeline side: drives decode/status, consumes operands and controls
  modport master (
    output I_dec_valid, I_dec_regA, I_dec_regB, I_dec_useA, I_dec_useB,
           I_dec_we, I_dec_regD, I_dec_isLoad, I_branch, I_ex_busy,
           I_dmem_busy, I_stage_data, I_regA, I_regB,
    input  O_opA, O_opB, O_fwdA, O_fwdB, O_stall, O_bubble, O_stall_cycles
  );

  // Hazard unit side
  modport slave (
    input  I_dec_valid, I_dec_regA, I_dec_regB, I_dec_useA, I_dec_useB,
           I_dec_we, I_dec_regD, I_dec_isLoad, I_branch, I_ex_busy,
           I_dmem_busy, I_stage_data, I_regA, I_regB,
    output O_opA, O_opB, O_fwdA, O_fwdB, O_stall, O_bubble, O_stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/ceespu_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : ceespu_hazard_unit
// Description : Scoreboard-based operand forwarding, load-use stall, busy
//               freeze and branch flush control for the ceespu pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module ceespu_hazard_unit #(
  parameter int XLEN      = 32,
  parameter int REGW      = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_REG  = 1
) (
  input  wire logic           I_clk,
  input  wire logic           I_rst,
  ceespu_hazard_unit_if.slave hz
);

  // Scoreboard: position 1 is execute, higher positions are older
  logic [FWD_DEPTH:1] sb_valid;
  logic [FWD_DEPTH:1] sb_load;
  logic [REGW-1:0]    sb_reg [1:FWD_DEPTH];
  logic [31:0]        stall_cnt;

  logic [2:0]      sel_a, sel_b;
  logic [XLEN-1:0] fwd_data_a, fwd_data_b;
  logic            ready_a, ready_b;
  logic            zero_a, zero_b, zero_d;
  logic            loaduse, freeze, new_valid;

  assign zero_a    = (ZERO_REG != 0) && (hz.I_dec_regA == '0);
  assign zero_b    = (ZERO_REG != 0) && (hz.I_dec_regB == '0);
  assign zero_d    = (ZERO_REG != 0) && (hz.I_dec_regD == '0);
  assign new_valid = hz.I_dec_valid && hz.I_dec_we && !zero_d;
  assign freeze    = hz.I_ex_busy || hz.I_dmem_busy;

  // Match search from oldest to youngest so the youngest match wins last
  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    fwd_data_a = hz.I_regA;
    fwd_data_b = hz.I_regB;
    ready_a    = 1'b1;
    ready_b    = 1'b1;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (sb_valid[k] && hz.I_dec_useA && !zero_a && (sb_reg[k] == hz.I_dec_regA)) begin
        sel_a      = 3'(k);
        fwd_data_a = hz.I_stage_data[(k-1)*XLEN +: XLEN];
        ready_a    = !sb_load[k] || (k > LOAD_LAT);
      end
      if (sb_valid[k] && hz.I_dec_useB && !zero_b && (sb_reg[k] == hz.I_dec_regB)) begin
        sel_b      = 3'(k);
        fwd_data_b = hz.I_stage_data[(k-1)*XLEN +: XLEN];
        ready_b    = !sb_load[k] || (k > LOAD_LAT);
      end
    end
  end

  assign loaduse = hz.I_dec_valid && (!ready_a || !ready_b);

  // Output resolution: reset > freeze > branch > loaduse > normal
  always_comb begin
    hz.O_stall  = 1'b0;
    hz.O_bubble = 1'b0;
    hz.O_fwdA   = '0;
    hz.O_fwdB   = '0;
    hz.O_opA    = hz.I_regA;
    hz.O_opB    = hz.I_regB;
    if (I_rst) begin
      hz.O_fwdA = sel_a;
      hz.O_fwdB = sel_b;
      hz.O_opA  = fwd_data_a;
      hz.O_opB  = fwd_data_b;
      if (freeze) begin
        hz.O_stall = 1'b1;
      end else if (hz.I_branch) begin
        hz.O_bubble = 1'b1;
      end else if (loaduse) begin
        hz.O_stall  = 1'b1;
        hz.O_bubble = 1'b1;
      end
    end
  end

  assign hz.O_stall_cycles = stall_cnt;

  // Scoreboard shift and load-use stall counter; both hold while frozen
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      sb_valid  <= '0;
      sb_load   <= '0;
      stall_cnt <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        sb_reg[k] <= '0;
      end
    end else if (!freeze) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_load[k]  <= sb_load[k-1];
        sb_reg[k]   <= sb_reg[k-1];
      end
      // A flushed or stalled decode slot enters execute as a bubble
      sb_valid[1] <= (hz.I_branch || loaduse) ? 1'b0 : new_valid;
      sb_load[1]  <= hz.I_dec_isLoad;
      sb_reg[1]   <= hz.I_dec_regD;
      if (!hz.I_branch && loaduse && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ceespu_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ceespu_hazard_unit
// Description : Directed self-checking bench for ceespu_hazard_unit using a
//               default instance and a FWD_DEPTH=4 / LOAD_LAT=2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ceespu_hazard_unit;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  ceespu_hazard_unit_if #(.XLEN(32), .REGW(5), .FWD_DEPTH(2)) bus_a ();
  ceespu_hazard_unit_if #(.XLEN(32), .REGW(5), .FWD_DEPTH(4)) bus_b ();

  ceespu_hazard_unit #(.XLEN(32), .REGW(5), .FWD_DEPTH(2), .LOAD_LAT(1), .ZERO_REG(1)) dut_a (
    .I_clk (clk),
    .I_rst (rst_a),
    .hz    (bus_a.slave)
  );

  ceespu_hazard_unit #(.XLEN(32), .REGW(5), .FWD_DEPTH(4), .LOAD_LAT(2), .ZERO_REG(1)) dut_b (
    .I_clk (clk),
    .I_rst (rst_b),
    .hz    (bus_b.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_a(input logic v, input logic we, input logic [4:0] rd, input logic ld,
                       input logic [4:0] ra, input logic ua, input logic [4:0] rb, input logic ub);
    bus_a.I_dec_valid  = v;
    bus_a.I_dec_we     = we;
    bus_a.I_dec_regD   = rd;
    bus_a.I_dec_isLoad = ld;
    bus_a.I_dec_regA   = ra;
    bus_a.I_dec_useA   = ua;
    bus_a.I_dec_regB   = rb;
    bus_a.I_dec_useB   = ub;
    #1;
  endtask

  task automatic dec_b(input logic v, input logic we, input logic [4:0] rd, input logic ld,
                       input logic [4:0] ra, input logic ua);
    bus_b.I_dec_valid  = v;
    bus_b.I_dec_we     = we;
    bus_b.I_dec_regD   = rd;
    bus_b.I_dec_isLoad = ld;
    bus_b.I_dec_regA   = ra;
    bus_b.I_dec_useA   = ua;
    bus_b.I_dec_regB   = 5'd0;
    bus_b.I_dec_useB   = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    bus_a.I_branch     = 1'b0;
    bus_a.I_ex_busy    = 1'b0;
    bus_a.I_dmem_busy  = 1'b0;
    bus_a.I_stage_data = {32'h0000_0022, 32'h0000_0011};
    bus_a.I_regA       = 32'h0000_AAAA;
    bus_a.I_regB       = 32'h0000_BBBB;
    bus_b.I_branch     = 1'b0;
    bus_b.I_ex_busy    = 1'b0;
    bus_b.I_dmem_busy  = 1'b0;
    bus_b.I_stage_data = {32'h0000_0404, 32'h0000_0303, 32'h0000_0202, 32'h0000_0101};
    bus_b.I_regA       = 32'h0000_A0A0;
    bus_b.I_regB       = 32'h0000_B0B0;
    dec_a(1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1);
    dec_b(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();

    // Reset-low outputs and reset state
    check("rst_stall", 32'(bus_a.O_stall), 32'd0);
    check("rst_fwdA", 32'(bus_a.O_fwdA), 32'd0);
    check("rst_opA", bus_a.O_opA, 32'h0000_AAAA);
    check("rst_cnt", bus_a.O_stall_cycles, 32'd0);
    rst_a = 1'b1;

    // ADD r3, then dependents one and two cycles later
    dec_a(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("add_nostall", 32'(bus_a.O_stall), 32'd0);
    tick();
    dec_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    check("dep1_fwdA", 32'(bus_a.O_fwdA), 32'd1);
    check("dep1_opA", bus_a.O_opA, 32'h0000_0011);
    check("dep1_stall", 32'(bus_a.O_stall), 32'd0);
    tick();
    check("dep2_fwdA", 32'(bus_a.O_fwdA), 32'd2);
    check("dep2_opA", bus_a.O_opA, 32'h0000_0022);
    tick();

    // LW r4 then dependent on regB: one stall cycle
    dec_a(1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    dec_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    check("lu_stall", 32'(bus_a.O_stall), 32'd1);
    check("lu_bubble", 32'(bus_a.O_bubble), 32'd1);
    check("lu_fwdB1", 32'(bus_a.O_fwdB), 32'd1);
    tick();
    check("lu_done_stall", 32'(bus_a.O_stall), 32'd0);
    check("lu_done_fwdB", 32'(bus_a.O_fwdB), 32'd2);
    check("lu_done_opB", bus_a.O_opB, 32'h0000_0022);
    check("lu_cnt", bus_a.O_stall_cycles, 32'd1);
    tick();

    // Two writes to r5: youngest wins; r0 never forwarded
    dec_a(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    dec_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
    check("young_fwdA", 32'(bus_a.O_fwdA), 32'd1);
    check("young_fwdB", 32'(bus_a.O_fwdB), 32'd1);
    check("young_opB", bus_a.O_opB, 32'h0000_0011);
    dec_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    check("r0_fwdA", 32'(bus_a.O_fwdA), 32'd0);
    check("r0_opA", bus_a.O_opA, 32'h0000_AAAA);
    check("unused_fwdB", 32'(bus_a.O_fwdB), 32'd0);
    tick();

    // Freeze during a load-use stall
    dec_a(1'b1, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    dec_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
    bus_a.I_ex_busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("frz_stall", 32'(bus_a.O_stall), 32'd1);
      check("frz_bubble", 32'(bus_a.O_bubble), 32'd0);
      check("frz_fwdA", 32'(bus_a.O_fwdA), 32'd1);
      check("frz_cnt", bus_a.O_stall_cycles, 32'd1);
      tick();
    end
    bus_a.I_ex_busy = 1'b0;
    #1;
    check("frz_lu_stall", 32'(bus_a.O_stall), 32'd1);
    check("frz_lu_bubble", 32'(bus_a.O_bubble), 32'd1);
    tick();
    check("frz_after_stall", 32'(bus_a.O_stall), 32'd0);
    check("frz_after_fwdA", 32'(bus_a.O_fwdA), 32'd2);
    check("frz_after_cnt", bus_a.O_stall_cycles, 32'd2);
    tick();

    // Branch overrides load-use and discards the decode write
    dec_a(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    dec_a(1'b1, 1'b1, 5'd8, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    bus_a.I_branch = 1'b1;
    #1;
    check("br_stall", 32'(bus_a.O_stall), 32'd0);
    check("br_bubble", 32'(bus_a.O_bubble), 32'd1);
    tick();
    bus_a.I_branch = 1'b0;
    dec_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 5'd7, 1'b1);
    check("br_flushed_fwdA", 32'(bus_a.O_fwdA), 32'd0);
    check("br_load_fwdB", 32'(bus_a.O_fwdB), 32'd2);
    check("br_cnt", bus_a.O_stall_cycles, 32'd2);
    check("br_after_stall", 32'(bus_a.O_stall), 32'd0);

    // Deep pipeline: FWD_DEPTH=4, LOAD_LAT=2
    rst_b = 1'b1;
    dec_b(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
    tick();
    dec_b(1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    check("d_s1_stall", 32'(bus_b.O_stall), 32'd1);
    check("d_s1_fwdA", 32'(bus_b.O_fwdA), 32'd1);
    tick();
    check("d_s2_stall", 32'(bus_b.O_stall), 32'd1);
    check("d_s2_fwdA", 32'(bus_b.O_fwdA), 32'd2);
    tick();
    check("d_go_stall", 32'(bus_b.O_stall), 32'd0);
    check("d_go_fwdA", 32'(bus_b.O_fwdA), 32'd3);
    check("d_go_opA", bus_b.O_opA, 32'h0000_0303);
    check("d_go_cnt", bus_b.O_stall_cycles, 32'd2);
    tick();

    // Reset asserted during stall cycle 1
    dec_b(1'b1, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0);
    tick();
    dec_b(1'b1, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    check("d_r_stall_pre", 32'(bus_b.O_stall), 32'd1);
    rst_b = 1'b0;
    #1;
    check("d_r_low_stall", 32'(bus_b.O_stall), 32'd0);
    check("d_r_low_opA", bus_b.O_opA, 32'h0000_A0A0);
    tick();
    rst_b = 1'b1;
    #1;
    check("d_r_after_stall", 32'(bus_b.O_stall), 32'd0);
    check("d_r_after_fwdA", 32'(bus_b.O_fwdA), 32'd0);
    check("d_r_after_cnt", bus_b.O_stall_cycles, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
